// File: rtl/grf_write_scheduler_pkg.sv
// grf_write_scheduler_pkg: shared widths, FIFO defaults and register-mask helper
package grf_write_scheduler_pkg;
    localparam int RW = 5;
    localparam int DW_DEF = 32;
    localparam int DEPTH_DEF = 4;
    localparam int AW_DEF = 2;

    function automatic logic [31:0] reg_bit(input logic [RW-1:0] r);
        return 32'd1 << r;
    endfunction
endpackage

// File: rtl/grf_write_scheduler_if.sv
// grf_write_scheduler_if: pipeline/MDU producer signals and the GRF write port
interface grf_write_scheduler_if #(parameter int DW = 32);
    logic          pipe_we;
    logic [4:0]    pipe_wreg;
    logic [DW-1:0] pipe_wdata;
    logic          mdu_valid;
    logic [4:0]    mdu_wreg;
    logic [DW-1:0] mdu_wdata;
    logic          mdu_ready;
    logic          GRF_WE;
    logic [4:0]    Wreg;
    logic [DW-1:0] Wdata;
    logic [31:0]   pending;

    modport master (
        output pipe_we, pipe_wreg, pipe_wdata, mdu_valid, mdu_wreg, mdu_wdata,
        input  mdu_ready, GRF_WE, Wreg, Wdata, pending
    );
    modport slave (
        input  pipe_we, pipe_wreg, pipe_wdata, mdu_valid, mdu_wreg, mdu_wdata,
        output mdu_ready, GRF_WE, Wreg, Wdata, pending
    );
endinterface

// File: rtl/grf_write_scheduler_wb_result_fifo.sv
// wb_result_fifo: circular MDU result buffer with per-entry live bits and squash-by-register
module wb_result_fifo
    import grf_write_scheduler_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          push_live,
    input  logic [RW-1:0] push_wreg,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    input  logic          squash_en,
    input  logic [RW-1:0] squash_reg,
    output logic          head_live,
    output logic [RW-1:0] head_wreg,
    output logic [DW-1:0] head_data,
    output logic [AW:0]   count,
    output logic [31:0]   live_mask
);
    logic [DEPTH-1:0] live_q;
    logic [RW-1:0]    wreg_q [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;

    assign head_live = live_q[rd_ptr];
    assign head_wreg = wreg_q[rd_ptr];
    assign head_data = data_q[rd_ptr];

    // Popped slots drop their live bit, so live alone marks queued writes.
    always_comb begin
        live_mask = '0;
        for (int i = 0; i < DEPTH; i++)
            live_mask = live_mask | (live_q[i] ? reg_bit(wreg_q[i]) : 32'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            live_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (squash_en && wreg_q[i] == squash_reg) live_q[i] <= 1'b0;
            if (pop) begin
                live_q[rd_ptr] <= 1'b0;
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push) begin
                live_q[wr_ptr] <= push_live;
                wreg_q[wr_ptr] <= push_wreg;
                data_q[wr_ptr] <= push_data;
                wr_ptr <= wr_ptr + AW'(1);
            end
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk)
        if (!reset) assert (!(pop && count == '0)) else $error("wb_result_fifo: pop while empty");
endmodule

// File: rtl/grf_write_scheduler.sv
// grf_write_scheduler: arbitrates the GRF write port between pipeline writeback and queued MDU results
module grf_write_scheduler
    import grf_write_scheduler_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input logic clk,
    input logic reset,
    grf_write_scheduler_if.slave bus
);
    logic          pipe_hit, nonempty, fifo_wr, pop, push, push_live, head_live;
    logic [RW-1:0] head_wreg;
    logic [DW-1:0] head_data;
    logic [AW:0]   count;
    logic [31:0]   live_mask;

    assign pipe_hit = bus.pipe_we && bus.pipe_wreg != '0;
    assign nonempty = count != '0;
    assign fifo_wr  = nonempty && head_live;
    assign pop      = !reset && nonempty && !pipe_hit;
    assign bus.mdu_ready = !reset && count != (AW+1)'(DEPTH);
    assign push     = bus.mdu_valid && bus.mdu_ready && bus.mdu_wreg != '0;
    // A simultaneous pipeline write to the same register is younger, so the entry is born dead.
    assign push_live = !(pipe_hit && bus.pipe_wreg == bus.mdu_wreg);

    assign bus.GRF_WE  = !reset && (pipe_hit || fifo_wr);
    assign bus.Wreg    = reset ? '0 : pipe_hit ? bus.pipe_wreg : fifo_wr ? head_wreg : '0;
    assign bus.Wdata   = reset ? '0 : pipe_hit ? bus.pipe_wdata : fifo_wr ? head_data : '0;
    assign bus.pending = reset ? '0 : live_mask & ~32'd1;

    wb_result_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_live  (push_live),
        .push_wreg  (bus.mdu_wreg),
        .push_data  (bus.mdu_wdata),
        .pop        (pop),
        .squash_en  (pipe_hit),
        .squash_reg (bus.pipe_wreg),
        .head_live  (head_live),
        .head_wreg  (head_wreg),
        .head_data  (head_data),
        .count      (count),
        .live_mask  (live_mask)
    );
endmodule

// File: tb/tb_grf_write_scheduler.sv
// tb_grf_write_scheduler: directed self-checking bench for the GRF write scheduler
module tb_grf_write_scheduler;
    logic clk, reset;
    int checks = 0, errors = 0;

    grf_write_scheduler_if #(.DW(32)) bus();
    grf_write_scheduler dut (.clk(clk), .reset(reset), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pipe(input logic we, input logic [4:0] r, input logic [31:0] d);
        bus.pipe_we = we;
        bus.pipe_wreg = r;
        bus.pipe_wdata = d;
    endtask

    task automatic mdu(input logic v, input logic [4:0] r, input logic [31:0] d);
        bus.mdu_valid = v;
        bus.mdu_wreg = r;
        bus.mdu_wdata = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input string tag, input logic we, input logic [4:0] r, input logic [31:0] d);
        chk({tag, "_we"}, 64'(bus.GRF_WE), 64'(we));
        if (we) begin
            chk({tag, "_wreg"}, 64'(bus.Wreg), 64'(r));
            chk({tag, "_wdata"}, 64'(bus.Wdata), 64'(d));
        end
    endtask

    initial begin
        reset = 1'b1;
        pipe(0, 0, 0);
        mdu(0, 0, 0);
        tick();
        tick();
        chk("rst_we", 64'(bus.GRF_WE), 0);
        chk("rst_ready", 64'(bus.mdu_ready), 0);
        chk("rst_pending", 64'(bus.pending), 0);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", 64'(bus.mdu_ready), 1);
        chk("post_rst_count", 64'(dut.u_fifo.count), 0);

        // reset discards queued r5/r6
        pipe(1, 1, 32'h1);
        mdu(1, 5, 32'h11);
        tick();
        mdu(1, 6, 32'h22);
        #1;
        wr("qrst_pipe", 1, 1, 32'h1);
        chk("qrst_pend5", 64'(bus.pending), 64'(32'h20));
        tick();
        pipe(0, 0, 0);
        mdu(0, 0, 0);
        reset = 1'b1;
        #1;
        chk("qrst_in_we", 64'(bus.GRF_WE), 0);
        chk("qrst_in_pend", 64'(bus.pending), 0);
        tick();
        reset = 1'b0;
        #1;
        chk("qrst_pend", 64'(bus.pending), 0);
        chk("qrst_count", 64'(dut.u_fifo.count), 0);
        chk("qrst_ready", 64'(bus.mdu_ready), 1);
        chk("qrst_we0", 64'(bus.GRF_WE), 0);
        tick();
        chk("qrst_we1", 64'(bus.GRF_WE), 0);

        // drain on idle
        mdu(1, 3, 32'hDEADBEEF);
        #1;
        chk("drain_we_empty", 64'(bus.GRF_WE), 0);
        tick();
        mdu(0, 0, 0);
        #1;
        wr("drain", 1, 3, 32'hDEADBEEF);
        chk("drain_pend", 64'(bus.pending), 64'(32'h8));
        tick();
        chk("drain_we_after", 64'(bus.GRF_WE), 0);
        chk("drain_pend_after", 64'(bus.pending), 0);

        // pipeline priority over queued r4
        mdu(1, 4, 32'h44);
        pipe(1, 7, 32'h77);
        #1;
        wr("prio1", 1, 7, 32'h77);
        tick();
        mdu(0, 0, 0);
        #1;
        wr("prio2", 1, 7, 32'h77);
        chk("prio_pend4", 64'(bus.pending), 64'(32'h10));
        tick();
        wr("prio3", 1, 7, 32'h77);
        tick();
        pipe(0, 0, 0);
        #1;
        wr("prio4", 1, 4, 32'h44);
        tick();
        wr("prio_done", 0, 0, 0);
        chk("prio_pend_done", 64'(bus.pending), 0);

        // squash of a queued write by a younger pipeline write
        mdu(1, 9, 32'h99);
        tick();
        mdu(0, 0, 0);
        pipe(1, 9, 32'h100);
        #1;
        wr("sq_pipe", 1, 9, 32'h100);
        chk("sq_pend_before", 64'(bus.pending), 64'(32'h200));
        tick();
        pipe(0, 0, 0);
        #1;
        chk("sq_pend_after", 64'(bus.pending), 0);
        wr("sq_killed_pop", 0, 0, 0);
        chk("sq_count1", 64'(dut.u_fifo.count), 1);
        tick();
        wr("sq_idle", 0, 0, 0);
        chk("sq_count0", 64'(dut.u_fifo.count), 0);

        // same-cycle push and pipeline write to r10: entry born dead
        mdu(1, 10, 32'hA);
        pipe(1, 10, 32'hB);
        #1;
        wr("born_dead_pipe", 1, 10, 32'hB);
        tick();
        mdu(0, 0, 0);
        pipe(0, 0, 0);
        #1;
        chk("born_dead_pend", 64'(bus.pending), 0);
        wr("born_dead_pop", 0, 0, 0);
        chk("born_dead_count", 64'(dut.u_fifo.count), 1);
        tick();
        chk("born_dead_count0", 64'(dut.u_fifo.count), 0);

        // fill to full behind a busy pipe, then drain across the wrap
        pipe(1, 20, 32'h20);
        for (int k = 1; k <= 4; k++) begin
            mdu(1, 5'(k), 32'h100 + 32'(k));
            #1;
            chk("full_ready", 64'(bus.mdu_ready), 1);
            tick();
        end
        mdu(1, 5, 32'h105);
        #1;
        chk("full_ready0", 64'(bus.mdu_ready), 0);
        chk("full_count", 64'(dut.u_fifo.count), 4);
        chk("full_pend", 64'(bus.pending), 64'(32'h1E));
        wr("full_pipe", 1, 20, 32'h20);
        tick();
        pipe(0, 0, 0);
        #1;
        chk("full_pop_ready0", 64'(bus.mdu_ready), 0);
        wr("wrap_r1", 1, 1, 32'h101);
        tick();
        chk("wrap_ready", 64'(bus.mdu_ready), 1);
        wr("wrap_r2", 1, 2, 32'h102);
        tick();
        mdu(1, 6, 32'h106);
        #1;
        wr("wrap_r3", 1, 3, 32'h103);
        tick();
        mdu(0, 0, 0);
        #1;
        chk("wrap_count", 64'(dut.u_fifo.count), 3);
        wr("wrap_r4", 1, 4, 32'h104);
        tick();
        wr("wrap_r5", 1, 5, 32'h105);
        tick();
        wr("wrap_r6", 1, 6, 32'h106);
        chk("wrap_pend6", 64'(bus.pending), 64'(32'h40));
        tick();
        wr("wrap_done", 0, 0, 0);
        chk("wrap_count0", 64'(dut.u_fifo.count), 0);

        // register 0 is never written or queued
        pipe(1, 0, 32'hFF);
        mdu(1, 0, 32'hEE);
        #1;
        wr("r0_we", 0, 0, 0);
        chk("r0_ready", 64'(bus.mdu_ready), 1);
        tick();
        pipe(0, 0, 0);
        mdu(0, 0, 0);
        #1;
        chk("r0_count", 64'(dut.u_fifo.count), 0);
        chk("r0_pend", 64'(bus.pending), 0);
        wr("r0_we_after", 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
